fir_sum_pipe: RTL
=================

FIR_SUM_PIPE -- requirements
Module: fir_sum_pipe

Interface
REQ-001 SHALL have parameter W, default 16: input sample width, unsigned, 4..32.
REQ-002 SHALL have parameter N, default 4: tap count, a power of two, 2..16; L = log2(N).
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1: synchronous clear of history and pipeline.
REQ-006 SHALL have port in_valid, input, 1: the a sample is accepted on this edge.
REQ-007 SHALL have port a, input, W: input sample.
REQ-008 SHALL have port s, output, W+L: registered moving sum, or average (REQ-020).
REQ-009 SHALL have port out_valid, output, 1: s holds a valid full-window result.

Function
REQ-010 SHALL keep an N-deep tap delay line t[0..N-1] that shifts only on edges with in_valid=1: t[0]<=a, t[i]<=t[i-1].
REQ-011 SHALL ignore a and leave the taps unchanged on edges with in_valid=0.
REQ-012 SHALL sum the taps through a binary adder tree of L levels with one register stage per level, then an output register for s.
REQ-013 SHALL give each tree level width W+level, so no intermediate or final overflow is possible.
REQ-014 SHALL update s and out_valid exactly L+1 edges after the accepting edge E, i.e. at E+L+1 (N=4: 3 edges).
REQ-015 SHALL carry a valid bit alongside every tree stage, while the tree itself runs every cycle.
REQ-016 SHALL count accepted samples in a saturating fill counter of L+1 bits that saturates at N.
REQ-017 SHALL tag a sample "full" only if the fill count, including that sample, reaches N; out_valid = stage valid AND full tag.
REQ-018 SHALL hold s at its last value when out_valid=0, and SHALL deassert out_valid for exactly one cycle per idle input cycle (no bubbles collapsed).
REQ-019 SHALL have flush=1 at an edge clear taps, fill counter, tree registers, valid bits, s and out_valid to 0; flush wins over a simultaneous in_valid, and that sample is dropped.
REQ-020 SHALL, with FIR_AVG_EN defined, make s the rounded average (sum + N/2) >> L, zero-extended to W+L bits, with identical latency.
REQ-021 SHALL accept back-to-back in_valid=1 every cycle at full throughput, one result per accepted sample.

Reset
REQ-022 SHALL on reset=1 asynchronously set all taps, tree registers, valid bits, fill counter, s and out_valid to 0.
REQ-023 SHALL, on reset asserted mid-pipeline, discard in-flight results; out_valid first rises only after N new accepted samples + L+1 edges.
REQ-024 SHALL ignore in_valid and flush while reset=1.

Configuration
REQ-025 SHALL use macro FIR_AVG_EN: when defined, the output is the rounded average per REQ-020; when undefined, s is the full W+L-bit sum; ports and latency are identical in both builds.

Verification (W=16, N=4 unless noted)
REQ-026 SHALL cover: after reset, in_valid=1 with a=1,2,3,4 on consecutive edges -> out_valid first high 3 edges after the "4" edge, s=10; then a=5 -> s=14 next cycle.
REQ-027 SHALL cover: four samples of 0xFFFF back-to-back -> s=0x3FFFC, no overflow; with FIR_AVG_EN -> s=0x0FFFF.
REQ-028 SHALL cover: a=1,2,3,4 with in_valid=0 for 2 cycles between "2" and "3" -> same s=10; out_valid is a single-cycle pulse for that result; taps are unchanged during the gap.
REQ-029 SHALL cover: flush together with in_valid (a=7) after 3 accepted samples -> sample dropped, out_valid stays 0 until 4 further samples; s=0 after flush.
REQ-030 SHALL cover: reset asserted asynchronously mid-stream, between edges -> s=0 and out_valid=0 immediately, without waiting for an edge; refill behaves per REQ-023.
REQ-031 SHALL cover: N=8, W=8, eight samples of 0xFF, with FIR_AVG_EN -> latency 4 edges, s=0x0FF; average of 1,1,1,1,2,2,2,2 (sum 12) -> s=(12+4)>>3=2.

Source files
------------

// File: rtl/fir_sum_pipe.sv
// Moving-window sum over the last N accepted samples, built from a pipelined binary adder tree.
// Optional build macro FIR_AVG_EN turns the output into the rounded average (sum + N/2) >> log2(N).
module fir_sum_pipe #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [W-1:0]              a,
  output logic [W+$clog2(N)-1:0]    s,
  output logic                      out_valid
);

  localparam int L  = $clog2(N);
  localparam int NW = W + L;
  localparam logic [L:0] FILL_MAX = N[L:0];

  logic [W-1:0] taps [N];
  logic [L:0]   fill;
  logic [L:0]   fill_next;
  logic [L:0]   vld_q;
  logic [L:0]   full_q;
  logic [NW-1:0] root;
  logic [NW-1:0] result;
  logic          fire;

  always_comb begin
    fill_next = fill;
    if (fill != FILL_MAX)
      fill_next = fill + {{L{1'b0}}, 1'b1};
  end

  // Stage 0: delay line, fill counter, and the valid/full tags that travel beside the tree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) taps[i] <= '0;
      fill   <= '0;
      vld_q  <= '0;
      full_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) taps[i] <= '0;
      fill   <= '0;
      vld_q  <= '0;
      full_q <= '0;
    end else begin
      if (in_valid) begin
        taps[0] <= a;
        for (int i = 1; i < N; i++) taps[i] <= taps[i-1];
        fill <= fill_next;
      end
      vld_q  <= {vld_q[L-1:0], in_valid};
      full_q <= {full_q[L-1:0], in_valid && (fill_next == FILL_MAX)};
    end
  end

  // Level lvl holds N>>lvl partial sums, each W+lvl bits wide, so nothing can overflow.
  for (genvar lvl = 1; lvl <= L; lvl++) begin : g_lvl
    localparam int CNT = N >> lvl;
    localparam int LW  = W + lvl;
    for (genvar j = 0; j < CNT; j++) begin : g_node
      logic [LW-1:0] sum_q;
      logic [LW-1:0] lhs;
      logic [LW-1:0] rhs;
      if (lvl == 1) begin : g_leaf
        assign lhs = LW'(taps[2*j]);
        assign rhs = LW'(taps[2*j+1]);
      end else begin : g_inner
        assign lhs = LW'(g_lvl[lvl-1].g_node[2*j].sum_q);
        assign rhs = LW'(g_lvl[lvl-1].g_node[2*j+1].sum_q);
      end
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          sum_q <= '0;
        else if (flush)
          sum_q <= '0;
        else
          sum_q <= lhs + rhs;
      end
    end
  end

  assign root = g_lvl[L].g_node[0].sum_q;

`ifdef FIR_AVG_EN
  // N*(2^W-1) + N/2 stays below 2^(W+L), so the rounding add cannot wrap.
  assign result = (root + NW'(N/2)) >> L;
`else
  assign result = root;
`endif

  assign fire = vld_q[L] & full_q[L];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s         <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      s         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= fire;
      if (fire)
        s <= result;
    end
  end

endmodule
